// File: rtl/dual_port_ram_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port RAM among four clients.
// Up to two non-conflicting accesses are granted per cycle; read data returns one cycle later.
module dual_port_ram_arbiter #(
    parameter int data_width = 8,
    parameter int addr_width = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [3:0]                req_i,
    input  logic [3:0]                we_i,
    input  logic [4*addr_width-1:0]   addr_i,
    input  logic [4*data_width-1:0]   wdata_i,
    output logic [3:0]                gnt_o,
    output logic [3:0]                rvalid_o,
    output logic [4*data_width-1:0]   rdata_o,
    output logic                      ram_a_o,
    output logic                      ram_b_o,
    output logic [addr_width-1:0]     ram_addr_a_o,
    output logic [addr_width-1:0]     ram_addr_b_o,
    output logic [data_width-1:0]     ram_data_a_o,
    output logic [data_width-1:0]     ram_data_b_o,
    input  logic [data_width-1:0]     ram_out_a_i,
    input  logic [data_width-1:0]     ram_out_b_i
);

    logic [1:0]            ptr_q, ptr_d;
    logic                  inf_a_q, inf_a_d;
    logic                  inf_b_q, inf_b_d;
    logic [1:0]            own_a_q, own_a_d;
    logic [1:0]            own_b_q, own_b_d;

    logic                  sel_a, sel_b;
    logic [1:0]            idx_a, idx_b;
    logic [1:0]            cand;

    logic [addr_width-1:0] addr_arr  [4];
    logic [data_width-1:0] wdata_arr [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_arr[i]  = addr_i[i*addr_width +: addr_width];
            wdata_arr[i] = wdata_i[i*data_width +: data_width];
        end
    end

    // Port B takes the next requester after the port-A owner whose access does not
    // collide with it; two reads of one address are allowed to share the cycle.
    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        idx_a = 2'd0;
        idx_b = 2'd0;
        cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!rst_i && req_i[cand]) begin
                if (!sel_a) begin
                    sel_a = 1'b1;
                    idx_a = cand;
                end else if (!sel_b &&
                             !((addr_arr[cand] == addr_arr[idx_a]) &&
                               (we_i[cand] || we_i[idx_a]))) begin
                    sel_b = 1'b1;
                    idx_b = cand;
                end
            end
        end
    end

    always_comb begin
        gnt_o = 4'b0000;
        if (sel_a) gnt_o[idx_a] = 1'b1;
        if (sel_b) gnt_o[idx_b] = 1'b1;

        ram_a_o      = sel_a && we_i[idx_a];
        ram_addr_a_o = sel_a ? addr_arr[idx_a]  : '0;
        ram_data_a_o = sel_a ? wdata_arr[idx_a] : '0;
        ram_b_o      = sel_b && we_i[idx_b];
        ram_addr_b_o = sel_b ? addr_arr[idx_b]  : '0;
        ram_data_b_o = sel_b ? wdata_arr[idx_b] : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (sel_b)      ptr_d = idx_b + 2'd1;
        else if (sel_a) ptr_d = idx_a + 2'd1;

        inf_a_d = sel_a && !we_i[idx_a];
        own_a_d = idx_a;
        inf_b_d = sel_b && !we_i[idx_b];
        own_b_d = idx_b;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= 2'd0;
            inf_a_q <= 1'b0;
            inf_b_q <= 1'b0;
            own_a_q <= 2'd0;
            own_b_q <= 2'd0;
        end else begin
            ptr_q   <= ptr_d;
            inf_a_q <= inf_a_d;
            inf_b_q <= inf_b_d;
            own_a_q <= own_a_d;
            own_b_q <= own_b_d;
        end
    end

    // Returns are driven from the in-flight records alone, so a read granted just
    // before a reset edge still completes in the reset cycle.
    always_comb begin
        rvalid_o = 4'b0000;
        rdata_o  = '0;
        if (inf_a_q) begin
            rvalid_o[own_a_q] = 1'b1;
            rdata_o[own_a_q*data_width +: data_width] = ram_out_a_i;
        end
        if (inf_b_q) begin
            rvalid_o[own_b_q] = 1'b1;
            rdata_o[own_b_q*data_width +: data_width] = ram_out_b_i;
        end
    end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Directed bench for dual_port_ram_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_dual_port_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk;
    logic          rst;
    logic [3:0]    req, we;
    logic [4*AW-1:0] addr;
    logic [4*DW-1:0] wdata;
    logic [3:0]    gnt, rvalid;
    logic [4*DW-1:0] rdata;
    logic          ram_a, ram_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_data_a, ram_data_b;
    logic [DW-1:0] ram_out_a, ram_out_b;

    dual_port_ram_arbiter #(.data_width(DW), .addr_width(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .ram_a_o      (ram_a),
        .ram_b_o      (ram_b),
        .ram_addr_a_o (ram_addr_a),
        .ram_addr_b_o (ram_addr_b),
        .ram_data_a_o (ram_data_a),
        .ram_data_b_o (ram_data_b),
        .ram_out_a_i  (ram_out_a),
        .ram_out_b_i  (ram_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (ram_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_b) mem[ram_addr_b] <= ram_data_b;
        ram_out_a <= mem[ram_addr_a];
        ram_out_b <= mem[ram_addr_b];
    end

    typedef struct {
        int            cyc;
        int            owner;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          sb [$];
    logic [DW-1:0] shadow [64];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [3:0]    obs_gnt;

    int gcount [4];
    int last_cyc [4];
    int max_gap [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [4*AW-1:0] pk_a(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [4*DW-1:0] pk_d(input int d0, input int d1, input int d2, input int d3);
        return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] w,
                        input logic [4*AW-1:0] a, input logic [4*DW-1:0] d,
                        input logic [3:0] eg);
        logic [3:0]    exp_rv;
        logic [DW-1:0] exp_rd [4];
        ret_t          e;
        rst = r; req = rq; we = w; addr = a; wdata = d;
        @(negedge clk);
        exp_rv = 4'b0000;
        for (int i = 0; i < 4; i++) exp_rd[i] = '0;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            exp_rv[e.owner] = 1'b1;
            exp_rd[e.owner] = e.data;
        end
        check("rvalid", 32'(rvalid), 32'(exp_rv));
        for (int i = 0; i < 4; i++)
            check($sformatf("rdata[%0d]", i), 32'(rdata[i*DW +: DW]), 32'(exp_rd[i]));
        check("gnt", 32'(gnt), 32'(eg));
        check("ram_we_count", 32'($countones({ram_a, ram_b})), 32'($countones(eg & w)));
        if (eg == 4'b0000)
            check("ram_idle", 32'({ram_addr_a, ram_addr_b, ram_data_a, ram_data_b}), 32'd0);
        obs_gnt = gnt;
        for (int i = 0; i < 4; i++)
            if (eg[i] && !w[i]) sb.push_back('{cyc + 1, i, shadow[a[i*AW +: AW]]});
        for (int i = 0; i < 4; i++)
            if (eg[i] && w[i]) shadow[a[i*AW +: AW]] = d[i*DW +: DW];
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4*AW-1:0] a_pre;
        logic [4*DW-1:0] d_pre;
        int              n0;

        for (int i = 0; i < 64; i++) shadow[i] = '0;
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        a_pre = pk_a(16, 17, 18, 19);
        d_pre = pk_d(8'h3C, 8'hC3, 8'h5A, 8'h96);
        @(posedge clk);
        #1;

        // reset, then idle
        step(1'b1, 4'b0000, 4'b0000, '0, '0, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000, '0, '0, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000, '0, '0, 4'b0000);

        // write then read-back through another requester
        step(1'b0, 4'b0001, 4'b0001, pk_a(3, 0, 0, 0), pk_d(8'hA5, 0, 0, 0), 4'b0001);
        step(1'b0, 4'b0100, 4'b0000, pk_a(0, 0, 3, 0), '0, 4'b0100);
        step(1'b0, 4'b0000, 4'b0000, '0, '0, 4'b0000);

        // preload 16..19 and steer ptr back to 0
        step(1'b0, 4'b1111, 4'b1111, a_pre, d_pre, 4'b1001);
        step(1'b0, 4'b0110, 4'b1111, a_pre, d_pre, 4'b0110);
        step(1'b0, 4'b1000, 4'b0000, pk_a(0, 0, 0, 3), '0, 4'b1000);

        // continuous reads from all four; fairness
        n0 = cyc;
        for (int i = 0; i < 4; i++) begin
            gcount[i] = 0; last_cyc[i] = n0 - 1; max_gap[i] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b1111, 4'b0000, a_pre, '0, (k % 2 == 0) ? 4'b0011 : 4'b1100);
            for (int i = 0; i < 4; i++) begin
                if (obs_gnt[i]) begin
                    gcount[i]++;
                    if (cyc - 1 - last_cyc[i] > max_gap[i]) max_gap[i] = cyc - 1 - last_cyc[i];
                    last_cyc[i] = cyc - 1;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("grant_count[%0d]", i), 32'(gcount[i]), 32'd4);
            check($sformatf("gap_le_2[%0d]", i), 32'(max_gap[i] <= 2), 32'd1);
        end

        // write/write conflict at ptr=1, then shared read of one address
        step(1'b0, 4'b0001, 4'b0000, pk_a(3, 0, 0, 0), '0, 4'b0001);
        step(1'b0, 4'b1010, 4'b1010, pk_a(0, 5, 0, 5), pk_d(0, 8'h11, 0, 8'h33), 4'b0010);
        step(1'b0, 4'b1000, 4'b1000, pk_a(0, 5, 0, 5), pk_d(0, 8'h11, 0, 8'h33), 4'b1000);
        step(1'b0, 4'b1010, 4'b0000, pk_a(0, 5, 0, 5), '0, 4'b1010);

        // write/read conflict on one address
        step(1'b0, 4'b0101, 4'b0001, pk_a(5, 0, 5, 0), pk_d(8'h77, 0, 0, 0), 4'b0001);
        step(1'b0, 4'b0100, 4'b0000, pk_a(0, 0, 5, 0), '0, 4'b0100);

        // read to requester 1, then reset with requests held
        step(1'b0, 4'b0010, 4'b0000, a_pre, '0, 4'b0010);
        step(1'b1, 4'b1111, 4'b0000, a_pre, '0, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000, a_pre, '0, 4'b0000);
        step(1'b0, 4'b1111, 4'b0000, a_pre, '0, 4'b0011);
        step(1'b0, 4'b0000, 4'b0000, '0, '0, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000, '0, '0, 4'b0000);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
